// File: rtl/fp64_pkg.sv
// ============================================================================
// Module : fp64_pkg
// Brief  : Shared FP64 constants and controller state type for the FPU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp64_pkg;
  localparam int FP64_W    = 64;
  localparam int EXP_W     = 11;
  localparam int MAN_W     = 52;
  localparam int BIAS      = 1023;
  localparam int DIV_ITERS = 55;

  localparam logic [FP64_W-1:0] QNAN = 64'h7FF8000000000000;
  localparam logic [FP64_W-1:0] PINF = 64'h7FF0000000000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    PACK = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fp64_div_iter_if.sv
// ============================================================================
// Module : fp64_div_iter_if
// Brief  : Start/done handshake bundle between FPU control and the divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp64_div_iter_if;
  import fp64_pkg::*;

  logic              start;
  logic [FP64_W-1:0] N1;
  logic [FP64_W-1:0] N2;
  logic              busy;
  logic              done;
  logic [FP64_W-1:0] out;
  logic              dz;

  modport master (output start, N1, N2, input busy, done, out, dz);
  modport slave  (input start, N1, N2, output busy, done, out, dz);
endinterface

`default_nettype wire

// File: rtl/fp64_round_pack.sv
// ============================================================================
// Module : fp64_round_pack
// Brief  : Combinational RNE rounding and range packing of a 55-bit quotient.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp64_round_pack
  import fp64_pkg::*;
(
  input  logic                     sign,
  input  logic signed [12:0]       exp_in,
  input  logic [54:0]              quo,
  input  logic                     sticky,
  output logic [FP64_W-1:0]        result
);

  logic              w_rnd;
  logic [53:0]       w_sig;
  logic [MAN_W-1:0]  w_mant;
  logic signed [12:0] w_exp;

  always_comb begin
    // quo = {int, frac[51:0], G, R}; the rule reduces to G & (R | S | L)
    w_rnd  = quo[1] & (quo[0] | sticky | quo[2]);
    w_sig  = {1'b0, quo[54:2]} + 54'(w_rnd);
    w_mant = w_sig[53] ? w_sig[52:1] : w_sig[51:0];
    w_exp  = exp_in + $signed({12'b0, w_sig[53]});

    if (w_exp >= 13'sd2047) begin
      result = {sign, PINF[FP64_W-2:0]};
    end else if (w_exp <= 13'sd0) begin
      result = {sign, {(FP64_W-1){1'b0}}};
    end else begin
      result = {sign, w_exp[EXP_W-1:0], w_mant};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp64_div_iter.sv
// ============================================================================
// Module : fp64_div_iter
// Brief  : Multi-cycle radix-2 restoring IEEE-754 binary64 divider, RNE.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp64_div_iter
  import fp64_pkg::*;
#(
  parameter bit SPECIAL_FAST = 1'b1
)
(
  input  logic           clk,
  input  logic           rst,
  fp64_div_iter_if.slave bus
);

  state_t             r_state;
  logic [FP64_W-1:0]  r_n1, r_n2;
  logic [53:0]        r_rem;
  logic [52:0]        r_div;
  logic [54:0]        r_quo;
  logic [5:0]         r_cnt;
  logic               r_sign;
  logic signed [12:0] r_exp;
  logic               r_spec;
  logic [FP64_W-1:0]  r_spec_res;
  logic               r_spec_dz;
  logic               r_busy, r_done, r_dz;
  logic [FP64_W-1:0]  r_out;

  logic [EXP_W-1:0]   w_e1, w_e2;
  logic [MAN_W:0]     w_ma, w_mb;
  logic               w_z1, w_z2, w_i1, w_i2, w_nan1, w_nan2;
  logic               w_sign, w_adj;
  logic signed [12:0] w_exp;
  logic               w_spec, w_spec_dz;
  logic [FP64_W-1:0]  w_spec_res;
  logic               w_ge;
  logic [53:0]        w_diff, w_rem_next;
  logic [FP64_W-1:0]  w_packed;

  always_comb begin
    w_e1   = r_n1[FP64_W-2 -: EXP_W];
    w_e2   = r_n2[FP64_W-2 -: EXP_W];
    w_ma   = {1'b1, r_n1[MAN_W-1:0]};
    w_mb   = {1'b1, r_n2[MAN_W-1:0]};
    w_z1   = (w_e1 == '0);
    w_z2   = (w_e2 == '0);
    w_i1   = (w_e1 == '1) && (r_n1[MAN_W-1:0] == '0);
    w_i2   = (w_e2 == '1) && (r_n2[MAN_W-1:0] == '0);
    w_nan1 = (w_e1 == '1) && (r_n1[MAN_W-1:0] != '0);
    w_nan2 = (w_e2 == '1) && (r_n2[MAN_W-1:0] != '0);
    w_sign = r_n1[FP64_W-1] ^ r_n2[FP64_W-1];
    // Pre-normalise so the quotient always lands in [1,2)
    w_adj  = (w_ma < w_mb);
    w_exp  = $signed({2'b00, w_e1} - {2'b00, w_e2} + 13'(BIAS) - {12'b0, w_adj});

    w_spec     = 1'b1;
    w_spec_dz  = 1'b0;
    w_spec_res = QNAN;
    if (w_nan1 || w_nan2 || (w_z1 && w_z2) || (w_i1 && w_i2)) begin
      w_spec_res = QNAN;
    end else if (w_i1) begin
      w_spec_res = {w_sign, PINF[FP64_W-2:0]};
    end else if (w_i2) begin
      w_spec_res = {w_sign, {(FP64_W-1){1'b0}}};
    end else if (w_z2) begin
      w_spec_res = {w_sign, PINF[FP64_W-2:0]};
      w_spec_dz  = 1'b1;
    end else if (w_z1) begin
      w_spec_res = {w_sign, {(FP64_W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end

    w_ge       = (r_rem >= {1'b0, r_div});
    w_diff     = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    w_rem_next = w_diff << 1;
  end

  fp64_round_pack u_round_pack (
    .sign   (r_sign),
    .exp_in (r_exp),
    .quo    (r_quo),
    .sticky (|r_rem),
    .result (w_packed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_n1       <= '0;
      r_n2       <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_spec_dz  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_out      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_n1    <= bus.N1;
            r_n2    <= bus.N2;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_rem      <= w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
          r_div      <= w_mb;
          r_quo      <= '0;
          r_cnt      <= 6'(DIV_ITERS - 1);
          r_sign     <= w_sign;
          r_exp      <= w_exp;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_dz  <= w_spec_dz;
          if (SPECIAL_FAST && w_spec) begin
            r_out   <= w_spec_res;
            r_dz    <= w_spec_dz;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= DIV;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[53:0], w_ge};
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd0) begin
            r_state <= PACK;
          end
        end
        PACK: begin
          r_out   <= r_spec ? r_spec_res : w_packed;
          r_dz    <= r_spec & r_spec_dz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.dz   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_fp64_div_iter.sv
// ============================================================================
// Module : tb_fp64_div_iter
// Brief  : Scoreboard bench for fp64_div_iter (fast and fixed-latency builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp64_div_iter;

  typedef struct {
    logic [63:0] out;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  logic sel;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  fp64_div_iter_if bus_f ();
  fp64_div_iter_if bus_s ();

  fp64_div_iter #(.SPECIAL_FAST(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  fp64_div_iter #(.SPECIAL_FAST(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  wire        mon_busy = sel ? bus_s.busy : bus_f.busy;
  wire        mon_done = sel ? bus_s.done : bus_f.done;
  wire [63:0] mon_out  = sel ? bus_s.out  : bus_f.out;
  wire        mon_dz   = sel ? bus_s.dz   : bus_f.dz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic expect_res(input logic [63:0] o, input logic d, input int l);
    exp_t e;
    e.out = o;
    e.dz  = d;
    e.lat = l;
    sb.push_back(e);
  endtask

  // Drives start for one edge (edge 0) and returns at edge0 + 1 time unit.
  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    if (sel) begin
      bus_s.start = 1'b1; bus_s.N1 = a; bus_s.N2 = b;
    end else begin
      bus_f.start = 1'b1; bus_f.N1 = a; bus_f.N2 = b;
    end
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    bus_f.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [63:0] o, output logic d);
    lat = -1;
    o   = 'x;
    d   = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (mon_done) begin
        lat = i; o = mon_out; d = mon_dz;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_f.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_f: got %b expected 0", bus_f.busy); end
    n_cmp++; if (bus_f.done !== 1'b0) begin n_bad++; $display("FAIL rst_done_f: got %b expected 0", bus_f.done); end
    n_cmp++; if (bus_f.out !== 64'h0) begin n_bad++; $display("FAIL rst_out_f: got %h expected 0", bus_f.out); end
    n_cmp++; if (bus_f.dz !== 1'b0) begin n_bad++; $display("FAIL rst_dz_f: got %b expected 0", bus_f.dz); end
    n_cmp++; if (bus_s.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_s: got %b expected 0", bus_s.busy); end
    n_cmp++; if (bus_s.out !== 64'h0) begin n_bad++; $display("FAIL rst_out_s: got %h expected 0", bus_s.out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    logic [63:0] ta [8] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h4000000000000000,
                            64'h3FF0000000000000, 64'h4014000000000000, 64'h3FF0000000000000,
                            64'h7FE0000000000000, 64'h0010000000000000};
    logic [63:0] tb [8] = '{64'h4000000000000000, 64'h4008000000000000, 64'h4008000000000000,
                            64'h3FF0000000000000, 64'h4008000000000000, 64'hC000000000000000,
                            64'h3FE0000000000000, 64'h4000000000000000};
    logic [63:0] to [8] = '{64'h4008000000000000, 64'h3FD5555555555555, 64'h3FE5555555555555,
                            64'h3FF0000000000000, 64'h3FFAAAAAAAAAAAAB, 64'hBFE0000000000000,
                            64'h7FF0000000000000, 64'h0000000000000000};
    int          lat;
    logic [63:0] o;
    logic        d;
    exp_t        e;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_res(to[i], 1'b0, 57);
      launch(ta[i], tb[i]);
      if (i == 0) begin
        n_cmp++; if (mon_busy !== 1'b1) begin n_bad++; $display("FAIL norm_busy: got %b expected 1", mon_busy); end
      end
      wait_done(lat, o, d);
      e = sb.pop_front();
      n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL norm_out[%0d]: got %h expected %h", i, o, e.out); end
      n_cmp++; if (d !== e.dz) begin n_bad++; $display("FAIL norm_dz[%0d]: got %b expected %b", i, d, e.dz); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL norm_lat[%0d]: got %0d expected %0d", i, lat, e.lat); end
      n_cmp++; if (mon_busy !== 1'b0) begin n_bad++; $display("FAIL norm_idle[%0d]: got %b expected 0", i, mon_busy); end
    end
  endtask

  task automatic test_special(input logic slow);
    logic [63:0] ta [6] = '{64'hBFF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000,
                            64'h7FF0000000000001, 64'h4000000000000000, 64'h0000000000000000};
    logic [63:0] tb [6] = '{64'h0000000000000000, 64'h0000000000000000, 64'h4000000000000000,
                            64'h3FF0000000000000, 64'hFFF0000000000000, 64'hC000000000000000};
    logic [63:0] to [6] = '{64'hFFF0000000000000, 64'h7FF8000000000000, 64'h7FF0000000000000,
                            64'h7FF8000000000000, 64'h8000000000000000, 64'h8000000000000000};
    logic        tdz [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          lat;
    logic [63:0] o;
    logic        d;
    exp_t        e;
    sel = slow;
    for (int i = 0; i < 6; i++) begin
      expect_res(to[i], tdz[i], slow ? 57 : 1);
      launch(ta[i], tb[i]);
      wait_done(lat, o, d);
      e = sb.pop_front();
      n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL spec%0d_out[%0d]: got %h expected %h", slow, i, o, e.out); end
      n_cmp++; if (d !== e.dz) begin n_bad++; $display("FAIL spec%0d_dz[%0d]: got %b expected %b", slow, i, d, e.dz); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL spec%0d_lat[%0d]: got %0d expected %0d", slow, i, lat, e.lat); end
    end
    sel = 1'b0;
  endtask

  task automatic test_handshake;
    int          pulses;
    int          lat;
    logic [63:0] o;
    exp_t        e;
    sel    = 1'b0;
    pulses = 0;
    lat    = -1;
    o      = 'x;
    expect_res(64'h4008000000000000, 1'b0, 57);
    launch(64'h4018000000000000, 64'h4000000000000000);
    for (int i = 1; i <= 80; i++) begin
      if (i == 10) begin
        bus_f.start = 1'b1; bus_f.N1 = 64'h3FF0000000000000; bus_f.N2 = 64'h4008000000000000;
      end
      @(posedge clk); #1;
      bus_f.start = 1'b0;
      if (mon_done) begin
        pulses++;
        if (pulses == 1) begin lat = i; o = mon_out; end
      end
    end
    e = sb.pop_front();
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL hs_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL hs_out: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL hs_lat: got %0d expected %0d", lat, e.lat); end
    n_cmp++; if (mon_busy !== 1'b0) begin n_bad++; $display("FAIL hs_busy: got %b expected 0", mon_busy); end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [63:0] o;
    logic        d;
    exp_t        e;
    sel = 1'b0;
    expect_res(64'h4008000000000000, 1'b0, 57);
    expect_res(64'h3FD5555555555555, 1'b0, 57);
    launch(64'h4018000000000000, 64'h4000000000000000);
    wait_done(lat, o, d);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL b2b_out1: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, e.lat); end
    launch(64'h3FF0000000000000, 64'h4008000000000000);
    n_cmp++; if (mon_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_drop: got %b expected 0", mon_done); end
    n_cmp++; if (mon_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy2: got %b expected 1", mon_busy); end
    n_cmp++; if (mon_out !== 64'h4008000000000000) begin n_bad++; $display("FAIL b2b_hold: got %h expected 4008000000000000", mon_out); end
    wait_done(lat, o, d);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL b2b_out2: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, e.lat); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mon_out !== e.out) begin n_bad++; $display("FAIL b2b_stable: got %h expected %h", mon_out, e.out); end
  endtask

  task automatic test_reset_mid;
    int          pulses;
    int          lat;
    logic [63:0] o;
    logic        d;
    exp_t        e;
    sel    = 1'b0;
    pulses = 0;
    launch(64'h4018000000000000, 64'h4000000000000000);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (mon_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", mon_busy); end
    n_cmp++; if (mon_out !== 64'h0) begin n_bad++; $display("FAIL rmid_out: got %h expected 0", mon_out); end
    n_cmp++; if (mon_dz !== 1'b0) begin n_bad++; $display("FAIL rmid_dz: got %b expected 0", mon_dz); end
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (mon_done) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rmid_nodone: got %0d expected 0", pulses); end
    expect_res(64'h3FE5555555555555, 1'b0, 57);
    launch(64'h4000000000000000, 64'h4008000000000000);
    wait_done(lat, o, d);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_bad++; $display("FAIL rmid_after_out: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rmid_after_lat: got %0d expected %0d", lat, e.lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel   = 1'b0;
    rst   = 1'b1;
    bus_f.start = 1'b0; bus_f.N1 = '0; bus_f.N2 = '0;
    bus_s.start = 1'b0; bus_s.N1 = '0; bus_s.N2 = '0;
    test_reset();
    test_normal();
    test_special(1'b0);
    test_special(1'b1);
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
